tetris_2048_engine: RTL and testbench

Parametrised successor of the 4x4 drop-and-merge game core. Holds a ROWS x COLS grid of log2 tile values and accepts left/right/drop inputs. A dropped tile stacks on its column, then merges repeatedly downward, one merge per cycle. Sits between the button debouncers and the VGA board renderer, and adds cascade merges, win detection, full-column rejection, a true loss check and a verification spawn override.

---
 rtl/tetris_2048_pkg.sv | 20 ++
 rtl/tetris_lfsr16.sv | 28 ++
 rtl/tetris_2048_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_tetris_2048_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_2048_pkg.sv
// Shared definitions for the drop-and-merge game engine.
//   state_t    : engine control states
//   CELL_EMPTY : value of an empty grid cell
//   cell_index : flat position of cell (r,c) in a row-major board vector
package tetris_2048_pkg;

  typedef enum logic [1:0] {
    ST_SPAWN = 2'd0,
    ST_INPUT = 2'd1,
    ST_MERGE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int CELL_EMPTY = 0;

  function automatic int cell_index(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left every cycle.
//   clk, rst : clock and synchronous active-high reset (loads SEED)
//   lfsr     : current register contents
// Feedback taps are bits 15, 13, 12 and 10; SEED must be non-zero.
module tetris_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_r;
  logic        fb_s;

  assign fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign lfsr = lfsr_r;

  // Shift register with seed load on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], fb_s};
    end
  end

endmodule

// File: rtl/tetris_2048_engine.sv
// Drop-and-merge game core: a ROWS x COLS grid of log2 tile values.
//   clk, rst        : clock, synchronous active-high reset
//   btn_l/btn_r     : level inputs, rising edge moves the cursor
//   btn_drop        : level input, rising edge drops the pending tile
//   dbg_spawn_en/val: force the next spawned tile value
//   board_flat      : cell(r,c) at [(r*COLS+c)*CELL_W +: CELL_W]
//   score           : saturating score
//   cursor_col      : selected column
//   spawn_val       : pending tile
//   busy            : high while merging or spawning
//   drop_rej        : one-cycle pulse when a drop is refused
//   win, game_over  : sticky status flags
// Non-zero cells are always contiguous from the bottom of each column, so a
// drop lands on the highest-index empty row and merges cascade downward one
// step per cycle starting from the landed cell.
module tetris_2048_engine
  import tetris_2048_pkg::*;
#(
  parameter int          ROWS      = 4,
  parameter int          COLS      = 4,
  parameter int          CELL_W    = 5,
  parameter int          MAX_POW   = 11,
  parameter int          WIN_POW   = 11,
  parameter int          SCORE_W   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_l,
  input  logic                          btn_r,
  input  logic                          btn_drop,
  input  logic                          dbg_spawn_en,
  input  logic [CELL_W-1:0]             dbg_spawn_val,
  output logic [ROWS*COLS*CELL_W-1:0]   board_flat,
  output logic [SCORE_W-1:0]            score,
  output logic [$clog2(COLS)-1:0]       cursor_col,
  output logic [CELL_W-1:0]             spawn_val,
  output logic                          busy,
  output logic                          drop_rej,
  output logic                          win,
  output logic                          game_over
);

  localparam int CUR_W = $clog2(COLS);
  localparam int PTR_W = $clog2(ROWS);

  state_t                    state_r, state_n;
  logic [CELL_W-1:0]         cells_r [ROWS][COLS];
  logic [CELL_W-1:0]         cells_n [ROWS][COLS];
  logic [SCORE_W-1:0]        score_r, score_n;
  logic [CUR_W-1:0]          cursor_r, cursor_n;
  logic [CELL_W-1:0]         spawn_r, spawn_n;
  logic [PTR_W-1:0]          ptr_r, ptr_n;
  logic                      busy_r, busy_n;
  logic                      rej_r, rej_n;
  logic                      win_r, win_n;
  logic                      over_r, over_n;
  logic                      btn_l_q_r, btn_r_q_r, btn_drop_q_r;

  logic                      do_l_s, do_r_s, do_drop_s;
  logic [15:0]               lfsr_s;
  logic                      unused_lfsr_s;
  logic                      col_has_empty_s;
  logic [PTR_W-1:0]          land_row_s;
  logic [CELL_W-1:0]         top_v_s;
  logic [CELL_W-1:0]         cur_v_s;
  logic [CELL_W-1:0]         below_v_s;
  logic [PTR_W-1:0]          ptr_next_s;
  logic                      can_merge_s;
  logic [CELL_W-1:0]         new_spawn_s;
  logic                      any_win_s;
  logic                      all_blocked_s;

  // Adds 2^p to s, clamping at all-ones; p at or beyond SCORE_W always clamps.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input int p);
    logic [SCORE_W:0] sum;
    if (p >= SCORE_W) begin
      sat_add = {SCORE_W{1'b1}};
    end else begin
      sum     = {1'b0, s} + ({{SCORE_W{1'b0}}, 1'b1} << p);
      sat_add = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end
  endfunction

  tetris_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:4];

  assign do_l_s    = btn_l & ~btn_l_q_r;
  assign do_r_s    = btn_r & ~btn_r_q_r;
  assign do_drop_s = btn_drop & ~btn_drop_q_r;

  // Button history for edge detection; deliberately tracks the pins during reset too.
  always_ff @(posedge clk) begin
    btn_l_q_r    <= btn_l;
    btn_r_q_r    <= btn_r;
    btn_drop_q_r <= btn_drop;
  end

  // Column scan, merge-step operands, win and loss conditions.
  always_comb begin
    col_has_empty_s = 1'b0;
    land_row_s      = {PTR_W{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      // Later (lower) empty rows override, giving the highest-index empty row.
      land_row_s      = (cells_r[r][cursor_r] == CELL_W'(CELL_EMPTY)) ? PTR_W'(r) : land_row_s;
      col_has_empty_s = col_has_empty_s | (cells_r[r][cursor_r] == CELL_W'(CELL_EMPTY));
    end
    top_v_s     = cells_r[0][cursor_r];
    cur_v_s     = cells_r[ptr_r][cursor_r];
    ptr_next_s  = (int'(ptr_r) < ROWS - 1) ? ptr_r + PTR_W'(1'b1) : ptr_r;
    below_v_s   = cells_r[ptr_next_s][cursor_r];
    can_merge_s = (int'(ptr_r) < ROWS - 1) && (below_v_s == cur_v_s) &&
                  (cur_v_s < CELL_W'(MAX_POW));
    new_spawn_s = dbg_spawn_en ? dbg_spawn_val :
                  ((lfsr_s[3:0] > 4'd1) ? CELL_W'(1'b1) : CELL_W'(2'd2));
    any_win_s     = 1'b0;
    all_blocked_s = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        any_win_s = any_win_s | (cells_r[r][c] >= CELL_W'(WIN_POW));
      end
    end
    for (int c = 0; c < COLS; c++) begin
      all_blocked_s = all_blocked_s & (cells_r[0][c] != CELL_W'(CELL_EMPTY)) &
                      (cells_r[0][c] != new_spawn_s);
    end
  end

  // Next-state and datapath updates for the control FSM.
  always_comb begin
    state_n  = state_r;
    cells_n  = cells_r;
    score_n  = score_r;
    cursor_n = cursor_r;
    spawn_n  = spawn_r;
    ptr_n    = ptr_r;
    win_n    = win_r;
    over_n   = over_r;
    rej_n    = 1'b0;
    case (state_r)
      ST_INPUT: begin
        if (do_drop_s) begin
          // Drop wins over movement and uses the current cursor.
          if (col_has_empty_s) begin
            cells_n[land_row_s][cursor_r] = spawn_r;
            ptr_n   = land_row_s;
            state_n = ST_MERGE;
          end else if ((top_v_s == spawn_r) && (spawn_r < CELL_W'(MAX_POW))) begin
            cells_n[0][cursor_r] = top_v_s + CELL_W'(1'b1);
            score_n = sat_add(score_r, int'(top_v_s) + 1);
            ptr_n   = {PTR_W{1'b0}};
            state_n = ST_MERGE;
          end else begin
            rej_n = 1'b1;
          end
        end else if (do_l_s && !do_r_s) begin
          if (cursor_r != {CUR_W{1'b0}}) begin
            cursor_n = cursor_r - CUR_W'(1'b1);
          end else begin
            cursor_n = cursor_r;
          end
        end else if (do_r_s && !do_l_s) begin
          if (cursor_r != CUR_W'(COLS - 1)) begin
            cursor_n = cursor_r + CUR_W'(1'b1);
          end else begin
            cursor_n = cursor_r;
          end
        end else begin
          cursor_n = cursor_r;
        end
      end
      ST_MERGE: begin
        if (can_merge_s) begin
          cells_n[ptr_next_s][cursor_r] = cur_v_s + CELL_W'(1'b1);
          cells_n[ptr_r][cursor_r]      = CELL_W'(CELL_EMPTY);
          score_n = sat_add(score_r, int'(cur_v_s) + 1);
          ptr_n   = ptr_next_s;
        end else begin
          state_n = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        spawn_n = new_spawn_s;
        win_n   = win_r | any_win_s;
        if (all_blocked_s) begin
          over_n  = 1'b1;
          state_n = ST_OVER;
        end else begin
          state_n = ST_INPUT;
        end
      end
      ST_OVER: begin
        state_n = ST_OVER;
      end
      default: begin
        state_n = ST_SPAWN;
      end
    endcase
    busy_n = (state_n == ST_MERGE) || (state_n == ST_SPAWN);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_SPAWN;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells_r[r][c] <= CELL_W'(CELL_EMPTY);
        end
      end
      score_r  <= {SCORE_W{1'b0}};
      cursor_r <= CUR_W'(COLS / 2);
      spawn_r  <= CELL_W'(1'b1);
      ptr_r    <= {PTR_W{1'b0}};
      busy_r   <= 1'b0;
      rej_r    <= 1'b0;
      win_r    <= 1'b0;
      over_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      cells_r  <= cells_n;
      score_r  <= score_n;
      cursor_r <= cursor_n;
      spawn_r  <= spawn_n;
      ptr_r    <= ptr_n;
      busy_r   <= busy_n;
      rej_r    <= rej_n;
      win_r    <= win_n;
      over_r   <= over_n;
    end
  end

  // Flatten the grid onto the renderer bus.
  always_comb begin
    board_flat = {(ROWS*COLS*CELL_W){1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        board_flat[cell_index(r, c, COLS)*CELL_W +: CELL_W] = cells_r[r][c];
      end
    end
  end

  assign score      = score_r;
  assign cursor_col = cursor_r;
  assign spawn_val  = spawn_r;
  assign busy       = busy_r;
  assign drop_rej   = rej_r;
  assign win        = win_r;
  assign game_over  = over_r;

endmodule

// File: tb/tb_tetris_2048_engine.sv
// Scoreboard bench for tetris_2048_engine: a grid-level reference model
// predicts each drop outcome, and a monitor compares it when the engine
// finishes (busy falls) or refuses (drop_rej pulses).
module tb_tetris_2048_engine;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int CELL_W  = 5;
  localparam int MAX_POW = 11;
  localparam int WIN_POW = 11;
  localparam int SCORE_W = 10;
  localparam int BW      = ROWS * COLS * CELL_W;
  localparam longint SMAX = (longint'(1) << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst, btn_l, btn_r, btn_drop, dbg_spawn_en;
  logic [CELL_W-1:0]         dbg_spawn_val;
  logic [BW-1:0]             board_flat;
  logic [SCORE_W-1:0]        score;
  logic [$clog2(COLS)-1:0]   cursor_col;
  logic [CELL_W-1:0]         spawn_val;
  logic busy, drop_rej, win, game_over;

  tetris_2048_engine #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .MAX_POW(MAX_POW),
    .WIN_POW(WIN_POW), .SCORE_W(SCORE_W), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_drop(btn_drop),
    .dbg_spawn_en(dbg_spawn_en), .dbg_spawn_val(dbg_spawn_val),
    .board_flat(board_flat), .score(score), .cursor_col(cursor_col),
    .spawn_val(spawn_val), .busy(busy), .drop_rej(drop_rej), .win(win),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rej;
    logic [BW-1:0] board;
    longint        score;
    int            cursor;
    int            spawn;
    bit            win;
    bit            go;
    int            busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int     m_cell[ROWS][COLS];
  longint m_score;
  int     m_cursor, m_spawn;
  bit     m_win, m_over;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_model();
    logic [BW-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        b[(r*COLS+c)*CELL_W +: CELL_W] = CELL_W'(m_cell[r][c]);
    return b;
  endfunction

  function automatic int dut_cell(input int r, input int c);
    return int'(board_flat[(r*COLS+c)*CELL_W +: CELL_W]);
  endfunction

  task automatic model_reset(input int sp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_cell[r][c] = 0;
    m_score = 0; m_cursor = COLS / 2; m_spawn = sp; m_win = 0; m_over = 0;
  endtask

  task automatic add_score(input int k);
    m_score = m_score + (longint'(1) << k);
    if (m_score > SMAX) m_score = SMAX;
  endtask

  // Monitor: compares the oldest expectation whenever the DUT reports an outcome.
  task automatic mon_handle(input bit rej_kind, input int cycles);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event actual=%0d expected=none", rej_kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_is_reject", rej_kind, e.rej);
      chk_board("board", board_flat, e.board);
      chk("score", score, e.score);
      chk("cursor", cursor_col, e.cursor);
      chk("spawn_val", spawn_val, e.spawn);
      chk("win", win, e.win);
      chk("game_over", game_over, e.go);
      if (!rej_kind) chk("busy_cycles", cycles, e.busy_cycles);
    end
  endtask

  initial begin
    bit busy_prev;
    int busy_cnt;
    busy_prev = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        busy_prev = 0; busy_cnt = 0;
      end else begin
        if (drop_rej) mon_handle(1'b1, 0);
        if (busy) busy_cnt++;
        else if (busy_prev) begin
          mon_handle(1'b0, busy_cnt);
          busy_cnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic press(input bit l, input bit r, input bit d);
    @(negedge clk);
    btn_l = l; btn_r = r; btn_drop = d;
    @(negedge clk);
    btn_l = 0; btn_r = 0; btn_drop = 0;
  endtask

  task automatic wait_drained();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_q.size() == 0) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic move(input bit l, input bit r);
    if (!m_over) begin
      if (l && !r && m_cursor > 0) m_cursor--;
      else if (r && !l && m_cursor < COLS - 1) m_cursor++;
    end
    press(l, r, 1'b0);
    chk("cursor_move", cursor_col, m_cursor);
  endtask

  task automatic goto_col(input int t);
    while (m_cursor > t) move(1'b1, 1'b0);
    while (m_cursor < t) move(1'b0, 1'b1);
  endtask

  // Predict a drop from the game rules, queue the expectation, then press.
  task automatic issue_drop(input bit l, input bit r);
    exp_t e;
    int c, filled, ptr, merges;
    bit rej;
    c = m_cursor; filled = 0; merges = 0; ptr = 0; rej = 0;
    for (int i = 0; i < ROWS; i++) if (m_cell[i][c] != 0) filled++;
    if (filled < ROWS) begin
      ptr = ROWS - 1 - filled;
      m_cell[ptr][c] = m_spawn;
    end else if (m_cell[0][c] == m_spawn && m_spawn < MAX_POW) begin
      m_cell[0][c] = m_spawn + 1;
      add_score(m_cell[0][c]);
      ptr = 0;
    end else begin
      rej = 1;
    end
    if (!rej) begin
      while (ptr < ROWS - 1 && m_cell[ptr+1][c] == m_cell[ptr][c] && m_cell[ptr][c] < MAX_POW) begin
        m_cell[ptr+1][c] = m_cell[ptr][c] + 1;
        add_score(m_cell[ptr+1][c]);
        m_cell[ptr][c] = 0;
        ptr++; merges++;
      end
      m_spawn = int'(dbg_spawn_val);
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          if (m_cell[i][j] >= WIN_POW) m_win = 1;
      m_over = 1;
      for (int j = 0; j < COLS; j++)
        if (m_cell[0][j] == 0 || m_cell[0][j] == m_spawn) m_over = 0;
    end
    e.rej = rej; e.board = pack_model(); e.score = m_score; e.cursor = m_cursor;
    e.spawn = m_spawn; e.win = m_win; e.go = m_over;
    e.busy_cycles = rej ? 0 : merges + 2;
    exp_q.push_back(e);
    press(l, r, 1'b1);
    wait_drained();
  endtask

  task automatic drop_val(input int next_v);
    dbg_spawn_val = CELL_W'(next_v);
    issue_drop(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int sp);
    mon_en = 0;
    rst = 1; dbg_spawn_en = 1; dbg_spawn_val = CELL_W'(sp);
    btn_l = 0; btn_r = 0; btn_drop = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    model_reset(sp);
    mon_en = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seed;
    int lf_spawn, v;
    bit l, r;
    rst = 1; btn_l = 0; btn_r = 0; btn_drop = 0;
    dbg_spawn_en = 0; dbg_spawn_val = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    // Reset values, then three cycles of SPAWN->INPUT without busy
    chk_board("rst_board", board_flat, '0);
    chk("rst_score", score, 0);
    chk("rst_cursor", cursor_col, COLS / 2);
    chk("rst_spawn", spawn_val, 1);
    chk("rst_win", win, 0);
    chk("rst_game_over", game_over, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", busy, 0);
      @(negedge clk);
    end
    // First SPAWN sees the seed; low nibble 1 is not >1, so tile 2
    seed = 16'hACE1;
    lf_spawn = (seed[3:0] > 4'd1) ? 1 : 2;
    chk("lfsr_spawn", spawn_val, lf_spawn);
    model_reset(lf_spawn);
    mon_en = 1;

    // Cursor movement
    for (int i = 0; i < 4; i++) move(1'b1, 1'b0);
    chk("cursor_left_clamp", cursor_col, 0);
    for (int i = 0; i < 4; i++) move(1'b0, 1'b1);
    chk("cursor_right_clamp", cursor_col, COLS - 1);
    move(1'b1, 1'b1);
    chk("cursor_both", cursor_col, COLS - 1);

    // Cascade: col0 bottom-up 3,2,1 then drop 1
    do_reset(3);
    goto_col(0);
    drop_val(2); drop_val(1); drop_val(1); drop_val(1);
    chk("cascade_score", score, 28);
    chk("cascade_bottom", dut_cell(ROWS - 1, 0), 4);

    // Full column: col1 bottom-up 1,2,1,2
    goto_col(1);
    drop_val(2); drop_val(1); drop_val(2); drop_val(1);
    issue_drop(1'b0, 1'b0);             // spawn 1 onto top 2: refused
    goto_col(3);
    drop_val(2);
    goto_col(1);
    drop_val(1);                         // spawn 2 onto top 2: top becomes 3
    chk("full_top", dut_cell(0, 1), 3);
    chk("full_score", score, 36);

    // Win and saturation
    do_reset(11);
    drop_val(11);
    chk("win_set", win, 1);
    drop_val(10);
    chk("max_no_merge", dut_cell(ROWS - 2, 2), 11);
    drop_val(10);
    goto_col(3);
    drop_val(10); drop_val(10);
    chk("score_saturated", score, SMAX);
    drop_val(10); drop_val(1);
    chk("score_stays_sat", score, SMAX);

    // Reset in the middle of a merge
    do_reset(1);
    drop_val(1);
    mon_en = 0;
    press(1'b0, 1'b0, 1'b1);
    chk("midmerge_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    chk("midmerge_score", score, 0);
    chk_board("midmerge_board", board_flat, '0);

    // Loss: every column 1,2,1,2 bottom-up, final spawn 3
    do_reset(1);
    for (int c = 0; c < COLS; c++) begin
      goto_col(c);
      for (int k = 0; k < ROWS; k++) begin
        v = (k % 2 == 0) ? 2 : 1;
        if (c == COLS - 1 && k == ROWS - 1) v = 3;
        drop_val(v);
      end
    end
    chk("loss_game_over", game_over, 1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_board("over_frozen", board_flat, pack_model());
    chk("over_cursor", cursor_col, m_cursor);
    chk("over_busy", busy, 0);
    do_reset(1);
    chk("after_rst_over", game_over, 0);
    chk_board("after_rst_board", board_flat, '0);
    chk("after_rst_score", score, 0);

    // Randomized play
    do_reset(int'($urandom_range(1, 3)));
    for (int n = 0; n < 250; n++) begin
      if (m_over) do_reset(int'($urandom_range(1, 3)));
      dbg_spawn_val = CELL_W'($urandom_range(1, 3));
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 4) move(l, r);
      else issue_drop(l, r);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
